// File: rtl/riscvmc_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R, I-ALU, beq, jal).
// One state per cycle over the shared PC/ALU/memory datapath; fetch and
// load/store stall on MemReady and trap if memory stays silent too long.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory answers
// DECODE   | read registers, compute branch/jump target from OldPC+imm
// MEMADR   | compute load/store address RD1+imm
// MEMREAD  | load request at computed address, wait for MemReady
// MEMWB    | write loaded data to register file
// MEMWRITE | store request at computed address, wait for MemReady
// EXECR    | R-type ALU operation RD1 op RD2
// ALUWB    | write ALU result to register file
// EXECI    | I-type ALU operation RD1 op imm
// JAL      | PC <= target, compute link address OldPC+4
// BEQ      | compare RD1-RD2, take branch when Zero
// TRAP     | illegal opcode or memory timeout; held until reset
module riscvmc_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       Trap,
    output logic [3:0] State
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Last counter value before a timeout fires; meaningless when timeout is disabled.
    localparam logic [CNT_W-1:0] LP_CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_pcupdate;
    logic             w_branch;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);
    // A completing handshake takes priority over the timeout in the same cycle.
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_mem_state && !MemReady &&
                         (r_cnt == LP_CNT_LAST);

    // State register and memory wait counter (cleared whenever the state changes).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_mem_state && !MemReady)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (MemReady)       w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      w_next = S_MEMREAD;
                else if (op == OP_SW) w_next = S_MEMWRITE;
                else                  w_next = S_TRAP;
            end
            S_MEMREAD: begin
                if (MemReady)       w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWRITE: begin
                if (MemReady)       w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_EXECR:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_EXECI:  w_next = S_ALUWB;
            S_JAL:    w_next = S_ALUWB;
            S_BEQ:    w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore output decode; reset suppresses every enable and select in its own cycle.
    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        Trap       = 1'b0;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemReq     = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = MemReady;
                w_pcupdate = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
            end
            S_TRAP:  Trap = 1'b1;
            default: ;
        endcase
        if (reset) begin
            MemReq     = 1'b0;
            MemWrite   = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            Trap       = 1'b0;
            w_pcupdate = 1'b0;
            w_branch   = 1'b0;
        end
    end

    assign PCWrite = w_pcupdate | (w_branch & Zero);
    assign State   = r_state;

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        if (!reset) begin
            case (op)
                OP_SW:   ImmSrc = 2'b01;
                OP_BEQ:  ImmSrc = 2'b10;
                OP_JAL:  ImmSrc = 2'b11;
                default: ImmSrc = 2'b00;
            endcase
        end
    end

endmodule
